// File: rtl/uart_word_tx_if.sv
// Bus-side signals for uart_word_tx: write/read strobes, register select and data.
// The master drives the strobes, address and write data; the slave returns the registered read data.
interface uart_word_tx_if;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output write_enable, read_enable, address, data_in, input data_out);
  modport slave  (input write_enable, read_enable, address, data_in, output data_out);
endinterface

// File: rtl/uart_word_tx.sv
// Memory-mapped UART transmitter: 32-bit words are queued in a small FIFO and sent
// as four 8N1 frames, most significant byte first and LSB-first within each byte.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_word_tx_if.slave bus,
  output logic          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic          r_overflow;
  logic [31:0]   r_dataOut;
  logic [31:0]   r_shift;
  logic [1:0]    r_byteIdx;
  logic [2:0]    r_bitIdx;
  logic [CW-1:0] r_baudCnt;
  logic          r_tx;

  logic [1:0]    w_sel;
  logic          w_empty;
  logic          w_full;
  logic          w_txWrite;
  logic          w_push;
  logic          w_drop;
  logic          w_statWrite;
  logic          w_statRead;
  logic          w_busy;
  logic          w_bitDone;
  logic          w_pop;
  logic          w_nextByte;
  logic          w_txBit;
  logic [7:0]    w_curByte;
  logic [31:0]   w_status;

  assign w_sel       = bus.address[3:2];
  assign w_empty     = (r_wrPtr == r_rdPtr);
  assign w_full      = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_txWrite   = bus.write_enable && (w_sel == 2'd0);
  assign w_push      = w_txWrite && !w_full;
  assign w_drop      = w_txWrite && w_full;
  assign w_statWrite = bus.write_enable && (w_sel == 2'd1);
  assign w_statRead  = bus.read_enable && !bus.write_enable && (w_sel == 2'd1);
  assign w_busy      = (r_state != IDLE) || !w_empty;
  assign w_bitDone   = (r_baudCnt == BAUD_LAST);
  assign w_curByte   = r_shift[31:24];
  assign w_status    = {28'd0, r_overflow, w_empty, w_full, w_busy};

  assign bus.data_out = r_dataOut;
  assign uart_tx      = r_tx;

  // Fullness is the pre-edge value, so a write into a full FIFO is dropped even when a pop frees a slot at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_statWrite && bus.data_in[3]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dataOut <= 32'd0;
    end else if (w_statRead) begin
      r_dataOut <= w_status;
    end else begin
      r_dataOut <= 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // After the last stop bit a waiting word is popped straight into START, so consecutive words have no idle gap.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_nextByte  = 1'b0;
    w_txBit     = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextState = START;
        end
      end
      START: begin
        w_txBit = 1'b0;
        if (w_bitDone) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        w_txBit = w_curByte[r_bitIdx];
        if (w_bitDone && (r_bitIdx == 3'd7)) begin
          w_nextState = STOP;
        end
      end
      STOP: begin
        if (w_bitDone) begin
          if (r_byteIdx != 2'd3) begin
            w_nextByte  = 1'b1;
            w_nextState = START;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_nextState = START;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The line level is registered from the current state, so the start bit appears one edge after the pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift   <= 32'd0;
      r_byteIdx <= 2'd0;
      r_bitIdx  <= 3'd0;
      r_baudCnt <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= w_txBit;
      if (r_state == IDLE || w_bitDone) begin
        r_baudCnt <= '0;
      end else begin
        r_baudCnt <= r_baudCnt + CW'(1);
      end
      if (w_pop) begin
        r_shift   <= r_mem[r_rdPtr[AW-1:0]];
        r_byteIdx <= 2'd0;
      end else if (w_nextByte) begin
        r_shift   <= {r_shift[23:0], 8'h00};
        r_byteIdx <= r_byteIdx + 2'd1;
      end
      if (r_state == DATA && w_bitDone) begin
        r_bitIdx <= r_bitIdx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomised scoreboard bench for uart_word_tx: accepted words are predicted from FIFO/line-time
// arithmetic and a serial monitor decodes uart_tx frames and compares them against the queue.
module tb_uart_word_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LINE  = 40 * CPB;

  typedef struct {
    logic [31:0] word;
    int          startEdge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx;

  always #5 clk = ~clk;

  uart_word_tx_if bus ();

  uart_word_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  int vectors = 0;
  int miscompares = 0;
  int edgeCnt = 0;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Reference model: each accepted word's write edge and pop edge, plus the sticky overflow flag.
  int   wEdgeQ[$];
  int   pEdgeQ[$];
  int   lastPop = -1000000;
  bit   ovfModel = 1'b0;
  exp_t sbQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int fifoCount(input int r);
    int n = 0;
    foreach (wEdgeQ[i]) if (wEdgeQ[i] < r && pEdgeQ[i] >= r) n++;
    return n;
  endfunction

  function automatic logic [31:0] expStatus(input int r);
    int n;
    bit busy;
    n = fifoCount(r);
    busy = (n != 0);
    foreach (pEdgeQ[i]) if (pEdgeQ[i] < r && r <= pEdgeQ[i] + LINE) busy = 1'b1;
    return {28'd0, ovfModel, (n == 0), (n == DEPTH), busy};
  endfunction

  function automatic void clearModel();
    wEdgeQ.delete();
    pEdgeQ.delete();
    sbQ.delete();
    lastPop  = -1000000;
    ovfModel = 1'b0;
  endfunction

  // Drives one bus cycle for the next rising edge and predicts its effect; returns at the following negedge.
  task automatic applyStimulus(input bit we, input bit re, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] expRead);
    int w;
    int n;
    int p;
    logic [1:0] sel;
    exp_t e;
    w = edgeCnt + 1;
    sel = addr[3:2];
    expRead = 32'd0;
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.address      = addr;
    bus.data_in      = data;
    if (rst_n) begin
      if (!we && re && sel == 2'd1) expRead = expStatus(w);
      if (we && sel == 2'd0) begin
        n = fifoCount(w);
        if (n >= DEPTH) begin
          ovfModel = 1'b1;
        end else begin
          p = (lastPop + LINE > w + 1) ? lastPop + LINE : w + 1;
          wEdgeQ.push_back(w);
          pEdgeQ.push_back(p);
          lastPop = p;
          e.word = data;
          e.startEdge = p + 1;
          sbQ.push_back(e);
        end
      end else if (we && sel == 2'd1 && data[3]) begin
        ovfModel = 1'b0;
      end
    end
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
  endtask

  // Serial monitor: samples mid-cell, assembles four bytes MSB-byte first, pops the scoreboard per word.
  bit          monIn = 1'b0;
  int          monCnt;
  int          monStart;
  int          monStarts = 0;
  bit          monFrameOk;
  logic [31:0] monWord;
  int          monCell;
  int          monByte;
  int          monBit;
  exp_t        monExp;

  always @(negedge clk) begin
    if (!rst_n) begin
      monIn = 1'b0;
    end else begin
      if (!monIn && uart_tx === 1'b0) begin
        monIn      = 1'b1;
        monCnt     = 0;
        monWord    = 32'd0;
        monFrameOk = 1'b1;
        monStart   = edgeCnt;
        monStarts++;
      end
      if (monIn) begin
        if (monCnt % CPB == CPB / 2) begin
          monCell = monCnt / CPB;
          monByte = monCell / 10;
          monBit  = monCell % 10;
          if (monBit == 0 && uart_tx !== 1'b0) monFrameOk = 1'b0;
          else if (monBit == 9 && uart_tx !== 1'b1) monFrameOk = 1'b0;
          else if (monBit >= 1 && monBit <= 8) monWord[(3 - monByte) * 8 + (monBit - 1)] = uart_tx;
        end
        monCnt++;
        if (monCnt == LINE) begin
          monIn = 1'b0;
          if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_word: got 0x%08h, expected no frame", monWord);
          end else begin
            monExp = sbQ.pop_front();
            checkOutput("tx_word", monWord, monExp.word);
            checkOutput("tx_start_edge", 32'(monStart), 32'(monExp.startEdge));
            checkOutput("tx_framing", 32'(monFrameOk), 32'd1);
          end
        end
      end
    end
  end

  task automatic waitDrain();
    int n = 0;
    while ((sbQ.size() != 0 || monIn) && n < 8 * LINE) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending_words", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] e;
    logic [31:0] addr;
    logic [31:0] data;
    int kind;
    int target;
    int startsBefore;

    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.address      = 32'd0;
    bus.data_in      = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(uart_tx), 32'd1);
    checkOutput("reset_data_out", bus.data_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("idle_status", bus.data_out, e);
    checkOutput("idle_status_0x4", bus.data_out, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h4, 32'd0, e);
    checkOutput("data_out_after_read", bus.data_out, 32'd0);

    // Single word, then bus rules while it is on the line.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hA5C30F81, e);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("busy_status", bus.data_out, e);
    applyStimulus(1'b1, 1'b1, 32'h4, 32'd0, e);
    checkOutput("rw_same_cycle", bus.data_out, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'd0, e);
    checkOutput("read_txdata", bus.data_out, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'd0, e);
    checkOutput("read_unmapped", bus.data_out, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, e);
    waitDrain();

    // Burst of six back-to-back writes: one popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, $urandom, e);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("burst_status", bus.data_out, e);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h8, e);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("ovf_cleared_status", bus.data_out, e);
    checkOutput("ovf_cleared_bit", 32'(bus.data_out[3]), 32'd0);

    // Write into the full FIFO at the exact edge the transmitter pops the next word.
    target = pEdgeQ[pEdgeQ.size() - 4];
    while (edgeCnt + 1 < target) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0BAD0BAD, e);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("pop_push_status", bus.data_out, e);
    checkOutput("pop_push_status_0x9", bus.data_out, 32'h9);
    waitDrain();
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h8, e);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("drained_status_0x4", bus.data_out, 32'h4);

    // Reset during the data bits of the third byte; a write during reset must be ignored.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h3C5A_9612, e);
    target = pEdgeQ[pEdgeQ.size() - 1] + 1 + 24 * CPB;
    while (edgeCnt < target) @(negedge clk);
    rst_n = 1'b0;
    clearModel();
    startsBefore = monStarts;
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h12345678, e);
    checkOutput("reset_midframe_tx", 32'(uart_tx), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("post_reset_status", bus.data_out, e);
    checkOutput("post_reset_status_0x4", bus.data_out, 32'h4);
    repeat (2 * LINE) @(negedge clk);
    checkOutput("no_frames_after_reset", 32'(monStarts), 32'(startsBefore));

    // Random mix of writes, status reads, overflow clears, unmapped accesses and idle gaps.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 11);
      addr = $urandom;
      data = $urandom;
      case (kind)
        0, 1, 2, 3, 4, 5: begin
          addr[3:2] = 2'd0;
          applyStimulus(1'b1, 1'b0, addr, data, e);
        end
        6: begin
          addr[3:2] = 2'd1;
          applyStimulus(1'b0, 1'b1, addr, data, e);
          checkOutput("rand_status", bus.data_out, e);
        end
        7: begin
          addr[3:2] = 2'd1;
          applyStimulus(1'b1, 1'b0, addr, data, e);
        end
        8: begin
          addr[3:2] = 2'($urandom_range(2, 3));
          applyStimulus(data[0], !data[0], addr, data, e);
          checkOutput("rand_unmapped", bus.data_out, e);
        end
        default: repeat ($urandom_range(1, LINE)) @(negedge clk);
      endcase
    end
    waitDrain();
    applyStimulus(1'b0, 1'b1, 32'h4, 32'd0, e);
    checkOutput("final_status", bus.data_out, e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
